// File: rtl/aor_key_pkg.sv
// Shared state encoding, defaults and counter sizing for the AOR serial key loader.
package aor_key_pkg;

  localparam int          KEY_W_DEF     = 32;
  localparam logic [31:0] DECOY_KEY_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_COMMIT,
    ST_DONE,
    ST_ERR
  } aor_key_state_t;

  // One spare bit so the bit counter can hold KEY_W itself without wrapping.
  function automatic int cnt_width(input int key_w);
    return $clog2(key_w) + 1;
  endfunction

endpackage

// File: rtl/aor_key_shreg.sv
// MSB-first key shift register with synchronous clear and a running XOR of every bit shifted in.
module aor_key_shreg #(
  parameter int KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [KEY_W-1:0] q,
  output logic             parity
);

  // NOTE: the key register is reset like any control flop so a partial key can never outlive a reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      q      <= '0;
      parity <= 1'b0;
    end else if (shift_en) begin
      q      <= {q[KEY_W-2:0], din};
      parity <= parity ^ din;
    end
  end

endmodule

// File: rtl/aor_key_loader.sv
// Serial unlock-key loader feeding the locked AOR adder's keyinput bus.
// Optional trailing even-parity check is built when AOR_KEY_LOADER_PARITY_EN is defined.
module aor_key_loader
  import aor_key_pkg::*;
#(
  parameter int               KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] DECOY_KEY = KEY_W'(DECOY_KEY_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_start_i,
  input  logic             key_svalid_i,
  input  logic             key_sdata_i,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid_o,
  output logic             key_err_o,
  output logic             busy_o
);

  localparam int             CW       = cnt_width(KEY_W);
  localparam logic [CW-1:0]  LAST_BIT = CW'(KEY_W - 1);

  aor_key_state_t   state, next_state;
  logic [CW-1:0]    cnt;
  logic [KEY_W-1:0] shreg;
  logic             par;
  logic             enter_shift;
  logic             shift_bit;
  logic             commit;
  logic             set_err;

  aor_key_shreg #(.KEY_W(KEY_W)) u_shreg (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .clr      (enter_shift),
    .shift_en (shift_bit),
    .din      (key_sdata_i),
    .q        (shreg),
    .parity   (par)
  );

  // A start pulse wins in every state, so a half-shifted key is always thrown away.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    enter_shift = 1'b0;
    shift_bit   = 1'b0;
    commit      = 1'b0;
    set_err     = 1'b0;
    if (key_start_i) begin
      next_state  = ST_SHIFT;
      enter_shift = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: next_state = state;
        ST_SHIFT: begin
          if (key_svalid_i) begin
            shift_bit = 1'b1;
            if (cnt == LAST_BIT) begin
`ifdef AOR_KEY_LOADER_PARITY_EN
              next_state = ST_CHECK;
`else
              next_state = ST_COMMIT;
`endif
            end
          end
        end
`ifdef AOR_KEY_LOADER_PARITY_EN
        ST_CHECK: begin
          if (key_svalid_i) begin
            if (par ^ key_sdata_i) begin
              next_state = ST_ERR;
              set_err    = 1'b1;
            end else begin
              next_state = ST_COMMIT;
            end
          end
        end
`endif
        ST_COMMIT: begin
          commit     = 1'b1;
          next_state = ST_DONE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (enter_shift) begin
      cnt <= '0;
    end else if (shift_bit) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The decoy goes back on the bus the moment a reload starts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_o       <= DECOY_KEY;
      key_valid_o <= 1'b0;
    end else if (enter_shift) begin
      key_o       <= DECOY_KEY;
      key_valid_o <= 1'b0;
    end else if (commit) begin
      key_o       <= shreg;
      key_valid_o <= 1'b1;
    end
  end

`ifdef AOR_KEY_LOADER_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_err_o <= 1'b0;
    end else if (enter_shift) begin
      key_err_o <= 1'b0;
    end else if (set_err) begin
      key_err_o <= 1'b1;
    end
  end
`else
  logic unused_par;
  assign unused_par = par ^ set_err;
  assign key_err_o  = 1'b0;
`endif

  assign busy_o = (state == ST_SHIFT) || (state == ST_CHECK) || (state == ST_COMMIT);

endmodule

// File: tb/tb_aor_key_loader.sv
// Randomised scoreboard bench for aor_key_loader; runs with or without AOR_KEY_LOADER_PARITY_EN.
module tb_aor_key_loader;
  import aor_key_pkg::*;

  localparam int           KW   = 32;
  localparam logic [KW-1:0] DECOY = 32'h5A5A_C3C3;
  localparam logic [KW-1:0] GOLD  = 32'h34A3_BD0F;
`ifdef AOR_KEY_LOADER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_start, key_svalid, key_sdata;
  logic [KW-1:0] key;
  logic          key_valid, key_err, busy;

  aor_key_loader #(.KEY_W(KW), .DECOY_KEY(DECOY)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .key_start_i  (key_start),
    .key_svalid_i (key_svalid),
    .key_sdata_i  (key_sdata),
    .key_o        (key),
    .key_valid_o  (key_valid),
    .key_err_o    (key_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] key;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and return at the following falling edge.
  task automatic cyc(input logic s, input logic v, input logic d);
    key_start  = s;
    key_svalid = v;
    key_sdata  = d;
    @(negedge clk);
    key_start  = 1'b0;
    key_svalid = 1'b0;
    key_sdata  = 1'b0;
  endtask

  // mode 0: no gaps, 1: a stall before every bit, 2: random stalls.
  task automatic send_key(input logic [KW-1:0] k, input int mode, input bit bad, output bit busy_ok);
    exp_t e;
    logic pb;
    int   ones;
    ones    = $countones(k);
    pb      = (ones % 2) == 1;
    if (bad) pb = ~pb;
    e.key   = k;
    e.err   = bad && PAR;
    busy_ok = 1'b1;
    for (int i = KW - 1; i >= 0; i--) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)) begin
        busy_ok &= busy;
        cyc(1'b0, 1'b0, 1'($urandom));
      end
      if (i == 0 && !PAR) exp_q.push_back(e);
      busy_ok &= busy;
      cyc(1'b0, 1'b1, k[i]);
    end
    if (PAR) begin
      if (mode == 1) begin
        busy_ok &= busy;
        cyc(1'b0, 1'b0, 1'($urandom));
      end
      exp_q.push_back(e);
      busy_ok &= busy;
      cyc(1'b0, 1'b1, pb);
    end
  endtask

  // Scoreboard monitor: every commit or error event must match the oldest queued expectation.
  logic pv = 1'b0;
  logic pe = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((key_valid && !pv) || (key_err && !pe)) begin
        check("mon_event_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          me = exp_q.pop_front();
          check("mon_err", 64'(key_err), 64'(me.err));
          check("mon_valid", 64'(key_valid), 64'(!me.err));
          check("mon_key", 64'(key), 64'(me.err ? DECOY : me.key));
          check("mon_busy", 64'(busy), 64'd0);
        end
      end
    end
    pv = key_valid;
    pe = key_err;
  end

  initial begin
    bit            bok;
    bit            bad;
    int            mode;
    int            m;
    logic [KW-1:0] k;

    key_start  = 1'b0;
    key_svalid = 1'b0;
    key_sdata  = 1'b0;
    rst_n      = 1'b0;
    #12;
    check("reset_key", 64'(key), 64'(DECOY));
    check("reset_valid", 64'(key_valid), 64'd0);
    check("reset_err", 64'(key_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Gapless load of the golden key, commit two edges after the last qualified bit.
    cyc(1'b1, 1'b0, 1'b0);
    check("t1_busy_after_start", 64'(busy), 64'd1);
    send_key(GOLD, 0, 1'b0, bok);
    check("t1_valid_not_yet", 64'(key_valid), 64'd0);
    check("t1_busy_commit", 64'(busy), 64'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t1_valid", 64'(key_valid), 64'd1);
    check("t1_key", 64'(key), 64'(GOLD));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'($urandom));
    check("t1_done_key_hold", 64'(key), 64'(GOLD));
    check("t1_done_valid_hold", 64'(key_valid), 64'd1);
    check("t1_done_busy", 64'(busy), 64'd0);

    // Stall every other cycle.
    cyc(1'b1, 1'b0, 1'b0);
    send_key(GOLD, 1, 1'b0, bok);
    check("t2_valid_not_yet", 64'(key_valid), 64'd0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t2_valid", 64'(key_valid), 64'd1);
    check("t2_key", 64'(key), 64'(GOLD));
    check("t2_busy_throughout", 64'(bok), 64'd1);

    // Restart after 13 bits; the start edge also carries a qualified bit that must be dropped.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) cyc(1'b0, 1'b1, 1'($urandom));
    cyc(1'b1, 1'b1, 1'b1);
    send_key(GOLD, 0, 1'b0, bok);
    cyc(1'b0, 1'b0, 1'b0);
    check("t3_key", 64'(key), 64'(GOLD));
    check("t3_valid", 64'(key_valid), 64'd1);

    // Reload from DONE drops the old key immediately; then load an all-zero key.
    cyc(1'b1, 1'b0, 1'b0);
    check("t6_valid_drop", 64'(key_valid), 64'd0);
    check("t6_key_decoy", 64'(key), 64'(DECOY));
    send_key('0, 2, 1'b0, bok);
    cyc(1'b0, 1'b0, 1'b0);
    check("t6_key_zero", 64'(key), 64'd0);
    check("t6_valid", 64'(key_valid), 64'd1);

    // Asynchronous reset from DONE, then in the middle of a load.
    #2 rst_n = 1'b0;
    #1;
    check("t4_done_rst_key", 64'(key), 64'(DECOY));
    check("t4_done_rst_valid", 64'(key_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, GOLD[KW-1-i]);
    #2 rst_n = 1'b0;
    #1;
    check("t4_mid_rst_busy", 64'(busy), 64'd0);
    check("t4_mid_rst_valid", 64'(key_valid), 64'd0);
    check("t4_mid_rst_key", 64'(key), 64'(DECOY));
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < KW + 4; i++) cyc(1'b0, 1'b1, 1'($urandom));
    check("t4_ignored_valid", 64'(key_valid), 64'd0);
    check("t4_ignored_busy", 64'(busy), 64'd0);

`ifdef AOR_KEY_LOADER_PARITY_EN
    // Good parity commits, bad parity lands in the error state until the next start.
    cyc(1'b1, 1'b0, 1'b0);
    send_key(GOLD, 0, 1'b0, bok);
    cyc(1'b0, 1'b0, 1'b0);
    check("t5_good_key", 64'(key), 64'(GOLD));
    check("t5_good_valid", 64'(key_valid), 64'd1);
    cyc(1'b1, 1'b0, 1'b0);
    send_key(GOLD, 0, 1'b1, bok);
    check("t5_bad_err", 64'(key_err), 64'd1);
    check("t5_bad_key", 64'(key), 64'(DECOY));
    check("t5_bad_valid", 64'(key_valid), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'($urandom));
    check("t5_err_sticky", 64'(key_err), 64'd1);
    cyc(1'b1, 1'b0, 1'b0);
    check("t5_err_cleared", 64'(key_err), 64'd0);
    check("t5_busy_restart", 64'(busy), 64'd1);
`endif

    // Randomised loads with optional aborts, stalls and (when built) parity faults.
    for (int n = 0; n < 12; n++) begin
      k    = $urandom;
      bad  = PAR && ($urandom_range(0, 3) == 0);
      mode = $urandom_range(0, 2);
      cyc(1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        m = $urandom_range(1, KW - 1);
        for (int i = 0; i < m; i++) cyc(1'b0, 1'b1, 1'($urandom));
        cyc(1'b1, 1'($urandom), 1'($urandom));
      end
      send_key(k, mode, bad, bok);
      cyc(1'b0, 1'b0, 1'b0);
      if (bad) begin
        check("rnd_err", 64'(key_err), 64'd1);
        check("rnd_err_key", 64'(key), 64'(DECOY));
      end else begin
        check("rnd_valid", 64'(key_valid), 64'd1);
        check("rnd_key", 64'(key), 64'(k));
      end
      check("rnd_busy_during_load", 64'(bok), 64'd1);
    end

    cyc(1'b0, 1'b0, 1'b0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
